id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Pipelined instruction-decode stage for the 5-stage RISC-V core.
- Holds the register file (async reset, WB write-first bypass) and the immediate sign-extender.
- Forwards operands from EX/MEM/WB, detects load-use hazards, and registers all decoded operands into the ID/EX pipeline register with stall, bubble and flush control.
- Successor to the single-cycle decode stage; register count and data width are parametrised.

Parameters:
- XLEN, 32, datapath width in bits (must be ≥32).
- NREG, 32, number of architectural registers (power of two, ≤32).
- RAW, $clog2(NREG), register-address width. Derived; do not override.
- FWD_EN, 1, when 0 forwarding is disabled and any RAW hazard on EX/MEM destinations stalls instead.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_inst  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- if_pc4  in  XLEN  PC+4
- ctl_sext_op  in  3  immediate type: 0=I, 1=S, 2=B, 3=U, 4=J, 5=shamt (zero-ext inst[24:20]), others → 0
- ctl_rf_we  in  1  instruction writes rd
- ctl_rf_wsel  in  2  writeback select, carried through to EX
- ctl_use_rs1  in  1  instruction reads rs1
- ctl_use_rs2  in  1  instruction reads rs2
- ex_we  in  1  EX-stage instruction writes rd
- ex_rd  in  RAW  EX destination
- ex_is_load  in  1  EX instruction is a load
- ex_result  in  XLEN  EX ALU result
- mem_we  in  1  MEM writes rd
- mem_rd  in  RAW  MEM destination
- mem_result  in  XLEN  MEM final writeback value
- wb_we  in  1  WB register-file write enable
- wb_rd  in  RAW  WB destination
- wb_wd  in  XLEN  WB write data
- ex_flush  in  1  branch/jump redirect; kill ID contents
- id_stall  out  1  hold PC and IF/ID this cycle
- idex_valid  out  1  ID/EX slot valid
- idex_pc  out  XLEN  registered PC
- idex_pc4  out  XLEN  registered PC+4
- idex_rd1  out  XLEN  registered, forwarded rs1 value
- idex_rd2  out  XLEN  registered, forwarded rs2 value
- idex_ext  out  XLEN  registered immediate
- idex_rd  out  RAW  registered destination
- idex_we  out  1  registered write enable, forced 0 when idex_valid=0
- idex_wsel  out  2  registered writeback select

Behaviour:
- **Register addressing.** rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7]; each is truncated to RAW bits.
- **Register file.**
  - Writes on the rising clk edge when wb_we=1 and wb_rd≠0.
  - x0 always reads 0.
  - All registers clear to 0 on rst_n=0.
- **Operand selection**, per source operand, in priority order:
  - x0 → 0.
  - EX match (ex_we, ex_rd==rs, not a load) → ex_result.
  - MEM match → mem_result.
  - WB match → wb_wd.
  - Otherwise the RF array value.
  - Selection is combinational.
  - When FWD_EN=0, only the WB bypass remains.
- **Immediates.** Generated exactly per RV32I formats and sign-extended to XLEN; B and J immediates have bit 0 = 0.
- **Hazard / stall.**
  - Load-use: id_stall=1 when if_valid and ex_is_load and ex_we and ex_rd≠0 and ex_rd matches a used rs.
  - FWD_EN=0: also stall on any used-rs match with EX or MEM (we=1, rd≠0).
  - id_stall is combinational.
- **ID/EX register update** (clk edge), in priority order:
  - rst_n=0 (asynchronous): all outputs 0, idex_valid=0.
  - ex_flush=1: idex_valid=0, idex_we=0; other fields don't-care (hold). id_stall is forced to 0 during a flush.
  - id_stall=1: bubble; idex_valid=0, idex_we=0.
  - Otherwise: capture all fields; idex_valid=if_valid, idex_we=ctl_rf_we & if_valid.
- **Latency.** One cycle from IF/ID to ID/EX. A stall lasts exactly one cycle for a load-use hazard.
- **Reset mid-operation.** Drops the pending bubble/flush immediately; the first clean cycle after release captures normally.
- **Simultaneous WB write and read of the same register.** New data is returned (write-first).

Test Plan:
1. Reset then a WB write of x5=0x1234 (wb_we=1), then decode add x6,x5,x0 → idex_rd1=0x1234 next cycle, idex_rd2=0.
2. EX writes x3=0xAAAA, MEM writes x3=0xBBBB, WB writes x3=0xCCCC in the same cycle, then decode an instruction using x3 → idex_rd1=0xAAAA (EX priority); with ex_we=0 → 0xBBBB.
3. ex_is_load=1, ex_rd=x7, decode of an instruction using rs2=x7 → id_stall=1 for one cycle and idex_valid=0; next cycle (load in MEM), mem_result=0x55 → idex_rd2=0x55, idex_valid=1.
4. ex_flush=1 together with a load-use condition → id_stall=0, idex_valid=0, idex_we=0.
5. Immediates:
   - inst=0xFFF00093 (addi x1,x0,-1), sext_op=0 → idex_ext=0xFFFFFFFF.
   - J-type inst=0x0000006F, sext_op=4 → idex_ext=0.
   - Write to x0 with wb_wd=0x99 → a subsequent x0 read returns 0.
6. rst_n asserted low mid-stall → idex_valid=0 immediately and the RF reads 0; with FWD_EN=0, an EX match on a non-load stalls one cycle per hazard.

Source files
------------

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RISC-V decode stage: register file, immediates, forwarding, hazards, ID/EX register
//
// Purpose:
//   Decode stage of the 5-stage core. Reads rs1/rs2 from an internal register
//   file (WB write-first bypass), forwards EX/MEM results, detects load-use
//   hazards (and all EX/MEM RAW hazards when forwarding is disabled), builds the
//   sign-extended immediate and registers everything into the ID/EX slot with
//   flush > stall > capture priority.
//
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   if_valid, if_inst, if_pc, if_pc4  IF/ID contents
//   ctl_sext_op                       immediate type (0=I 1=S 2=B 3=U 4=J 5=shamt)
//   ctl_rf_we, ctl_rf_wsel            writeback enable / select for this instruction
//   ctl_use_rs1, ctl_use_rs2          instruction reads rs1 / rs2
//   ex_we, ex_rd, ex_is_load, ex_result   EX-stage destination and result
//   mem_we, mem_rd, mem_result        MEM-stage destination and result
//   wb_we, wb_rd, wb_wd               register-file write port
//   ex_flush                          redirect; kill the instruction in ID
//   id_stall                          hold PC and IF/ID this cycle
//   idex_*                            registered ID/EX slot

module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int FWD_EN = 1,
    localparam int RAW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pc4,
    input  logic [2:0]      ctl_sext_op,
    input  logic            ctl_rf_we,
    input  logic [1:0]      ctl_rf_wsel,
    input  logic            ctl_use_rs1,
    input  logic            ctl_use_rs2,
    input  logic            ex_we,
    input  logic [RAW-1:0]  ex_rd,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_we,
    input  logic [RAW-1:0]  mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            ex_flush,
    output logic            id_stall,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [XLEN-1:0] idex_pc4,
    output logic [XLEN-1:0] idex_rd1,
    output logic [XLEN-1:0] idex_rd2,
    output logic [XLEN-1:0] idex_ext,
    output logic [RAW-1:0]  idex_rd,
    output logic            idex_we,
    output logic [1:0]      idex_wsel
);

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [1:0][RAW-1:0] rs_addr;
    logic [1:0]          rs_used;
    logic [RAW-1:0]      rd_addr;

    assign rs_addr[0] = if_inst[15 +: RAW];
    assign rs_addr[1] = if_inst[20 +: RAW];
    assign rd_addr    = if_inst[7 +: RAW];
    assign rs_used    = {ctl_use_rs2, ctl_use_rs1};

    // Opcode bits are decoded upstream; only the operand/immediate fields matter here.
    logic unused_opcode;
    assign unused_opcode = ^if_inst[6:0];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we && (wb_rd != '0)) begin
            rf_q[wb_rd] <= wb_wd;
        end
    end

    // ------------------------------------------------------------------
    // Operand selection: x0, EX, MEM, WB bypass, array.
    // A load in EX has no result yet, so it is never a forwarding source;
    // that case is covered by the load-use stall instead.
    // ------------------------------------------------------------------
    logic [1:0][XLEN-1:0] opnd;

    always_comb begin
        opnd = '0;
        for (int k = 0; k < 2; k++) begin
            if (rs_addr[k] == '0) begin
                opnd[k] = '0;
            end else if ((FWD_EN != 0) && ex_we && !ex_is_load && (ex_rd == rs_addr[k])) begin
                opnd[k] = ex_result;
            end else if ((FWD_EN != 0) && mem_we && (mem_rd == rs_addr[k])) begin
                opnd[k] = mem_result;
            end else if (wb_we && (wb_rd == rs_addr[k])) begin
                opnd[k] = wb_wd;
            end else begin
                opnd[k] = rf_q[rs_addr[k]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection. Matching a non-zero used rs implies rd != 0.
    // ------------------------------------------------------------------
    logic hazard;

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (rs_used[k] && (rs_addr[k] != '0)) begin
                if (ex_we && (ex_rd == rs_addr[k]) && (ex_is_load || (FWD_EN == 0))) begin
                    hazard = 1'b1;
                end
                if ((FWD_EN == 0) && mem_we && (mem_rd == rs_addr[k])) begin
                    hazard = 1'b1;
                end
            end
        end
        // A flush kills the instruction anyway, so holding IF/ID would be wrong.
        id_stall = if_valid && hazard && !ex_flush;
    end

    // ------------------------------------------------------------------
    // Immediate generation: build the 32-bit RV32I immediate, then sign-extend.
    // ------------------------------------------------------------------
    logic [31:0]     imm32;
    logic [XLEN-1:0] ext_val;

    always_comb begin
        imm32 = '0;
        case (ctl_sext_op)
            3'd0:    imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
            3'd1:    imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
            3'd2:    imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                              if_inst[30:25], if_inst[11:8], 1'b0};
            3'd3:    imm32 = {if_inst[31:12], 12'b0};
            3'd4:    imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                              if_inst[20], if_inst[30:21], 1'b0};
            3'd5:    imm32 = {27'b0, if_inst[24:20]};
            default: imm32 = '0;
        endcase
    end

    assign ext_val = XLEN'($signed(imm32));

    // ------------------------------------------------------------------
    // ID/EX pipeline register: flush > stall (bubble) > capture.
    // Data fields hold on a bubble or flush; only valid/we are meaningful then.
    // ------------------------------------------------------------------
    logic            valid_q, valid_d;
    logic            we_q,    we_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] pc4_q,   pc4_d;
    logic [XLEN-1:0] rd1_q,   rd1_d;
    logic [XLEN-1:0] rd2_q,   rd2_d;
    logic [XLEN-1:0] ext_q,   ext_d;
    logic [RAW-1:0]  rd_q,    rd_d;
    logic [1:0]      wsel_q,  wsel_d;

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        ext_d   = ext_q;
        rd_d    = rd_q;
        wsel_d  = wsel_q;
        if (ex_flush || id_stall) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else begin
            valid_d = if_valid;
            we_d    = ctl_rf_we & if_valid;
            pc_d    = if_pc;
            pc4_d   = if_pc4;
            rd1_d   = opnd[0];
            rd2_d   = opnd[1];
            ext_d   = ext_val;
            rd_d    = rd_addr;
            wsel_d  = ctl_rf_wsel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ext_q   <= '0;
            rd_q    <= '0;
            wsel_q  <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ext_q   <= ext_d;
            rd_q    <= rd_d;
            wsel_q  <= wsel_d;
        end
    end

    assign idex_valid = valid_q;
    assign idex_we    = we_q;
    assign idex_pc    = pc_q;
    assign idex_pc4   = pc4_q;
    assign idex_rd1   = rd1_q;
    assign idex_rd2   = rd2_q;
    assign idex_ext   = ext_q;
    assign idex_rd    = rd_q;
    assign idex_wsel  = wsel_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard bench for id_stage_pipe (forwarding and non-forwarding builds)
module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef struct {
        logic        rst_n;
        logic        if_valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [2:0]  sext;
        logic        rf_we;
        logic [1:0]  wsel;
        logic        use1;
        logic        use2;
        logic        ex_we;
        logic [4:0]  ex_rd;
        logic        ex_is_load;
        logic [31:0] ex_result;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_result;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_wd;
        logic        flush;
    } stim_t;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        we;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  rd;
        logic [1:0]  wsel;
    } idex_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, if_valid, ctl_rf_we, ctl_use_rs1, ctl_use_rs2;
    logic [31:0] if_inst, if_pc, if_pc4;
    logic [2:0]  ctl_sext_op;
    logic [1:0]  ctl_rf_wsel;
    logic        ex_we, ex_is_load, mem_we, wb_we, ex_flush;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] ex_result, mem_result, wb_wd;

    logic        f_stall, f_valid, f_we;
    logic [31:0] f_pc, f_pc4, f_rd1, f_rd2, f_ext;
    logic [4:0]  f_rd;
    logic [1:0]  f_wsel;
    logic        n_stall, n_valid, n_we;
    logic [31:0] n_pc, n_pc4, n_rd1, n_rd2, n_ext;
    logic [4:0]  n_rd;
    logic [1:0]  n_wsel;

    id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .FWD_EN(1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4),
        .ctl_sext_op(ctl_sext_op), .ctl_rf_we(ctl_rf_we), .ctl_rf_wsel(ctl_rf_wsel),
        .ctl_use_rs1(ctl_use_rs1), .ctl_use_rs2(ctl_use_rs2),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_result(ex_result),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .ex_flush(ex_flush),
        .id_stall(f_stall), .idex_valid(f_valid), .idex_pc(f_pc), .idex_pc4(f_pc4),
        .idex_rd1(f_rd1), .idex_rd2(f_rd2), .idex_ext(f_ext), .idex_rd(f_rd),
        .idex_we(f_we), .idex_wsel(f_wsel)
    );

    id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .FWD_EN(0)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4),
        .ctl_sext_op(ctl_sext_op), .ctl_rf_we(ctl_rf_we), .ctl_rf_wsel(ctl_rf_wsel),
        .ctl_use_rs1(ctl_use_rs1), .ctl_use_rs2(ctl_use_rs2),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_result(ex_result),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .ex_flush(ex_flush),
        .id_stall(n_stall), .idex_valid(n_valid), .idex_pc(n_pc), .idex_pc4(n_pc4),
        .idex_rd1(n_rd1), .idex_rd2(n_rd2), .idex_ext(n_ext), .idex_rd(n_rd),
        .idex_we(n_we), .idex_wsel(n_wsel)
    );

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [1:0]  stall_q [$];
    idex_t       exp_f_q [$];
    idex_t       exp_n_q [$];
    logic [31:0] rf_m [32];
    idex_t       pend_f, pend_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic idex_t zero_idex();
        idex_t z;
        z = '{rst: 1'b1, valid: 1'b0, we: 1'b0, pc: 0, pc4: 0, rd1: 0, rd2: 0, ext: 0, rd: 0, wsel: 0};
        return z;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i, input logic [2:0] op);
        int signed si;
        si = $signed(i);
        case (op)
            3'd0: return 32'(si >>> 20);
            3'd1: return 32'((si >>> 25) << 5) | 32'(i[11:7]);
            3'd2: return 32'((si >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            3'd3: return i & 32'hFFFF_F000;
            3'd4: return 32'((si >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            3'd5: return 32'(i[24:20]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] operand(input stim_t s, input logic [4:0] rs, input bit fwd);
        if (rs == 0) return 32'h0;
        if (fwd && s.ex_we && !s.ex_is_load && s.ex_rd == rs) return s.ex_result;
        if (fwd && s.mem_we && s.mem_rd == rs) return s.mem_result;
        if (s.wb_we && s.wb_rd == rs) return s.wb_wd;
        return rf_m[rs];
    endfunction

    function automatic logic exp_stall(input stim_t s, input bit fwd);
        logic [4:0] srcs [2];
        logic       used [2];
        logic       st;
        srcs[0] = s.inst[19:15];
        srcs[1] = s.inst[24:20];
        used[0] = s.use1;
        used[1] = s.use2;
        st = 1'b0;
        if (s.if_valid && !s.flush) begin
            for (int k = 0; k < 2; k++) begin
                if (used[k] && srcs[k] != 0) begin
                    if (s.ex_we && s.ex_is_load && s.ex_rd == srcs[k]) st = 1'b1;
                    if (!fwd && s.ex_we && s.ex_rd == srcs[k]) st = 1'b1;
                    if (!fwd && s.mem_we && s.mem_rd == srcs[k]) st = 1'b1;
                end
            end
        end
        return st;
    endfunction

    function automatic idex_t next_idex(input idex_t cur, input stim_t s, input bit fwd, input logic st);
        idex_t n;
        n = cur;
        n.rst = 1'b0;
        if (s.flush || st) begin
            n.valid = 1'b0;
            n.we    = 1'b0;
        end else begin
            n.valid = s.if_valid;
            n.we    = s.rf_we & s.if_valid;
            n.pc    = s.pc;
            n.pc4   = s.pc4;
            n.rd1   = operand(s, s.inst[19:15], fwd);
            n.rd2   = operand(s, s.inst[24:20], fwd);
            n.ext   = imm_of(s.inst, s.sext);
            n.rd    = s.inst[11:7];
            n.wsel  = s.wsel;
        end
        return n;
    endfunction

    // One cycle: expectation for the edge just taken, then new inputs.
    task automatic step(input stim_t s);
        logic sf, sn;
        @(posedge clk);
        #1;
        if (!s.rst_n) begin
            pend_f = zero_idex();
            pend_n = zero_idex();
            for (int r = 0; r < 32; r++) rf_m[r] = 32'h0;
        end
        exp_f_q.push_back(pend_f);
        exp_n_q.push_back(pend_n);
        rst_n = s.rst_n; if_valid = s.if_valid; if_inst = s.inst; if_pc = s.pc; if_pc4 = s.pc4;
        ctl_sext_op = s.sext; ctl_rf_we = s.rf_we; ctl_rf_wsel = s.wsel;
        ctl_use_rs1 = s.use1; ctl_use_rs2 = s.use2;
        ex_we = s.ex_we; ex_rd = s.ex_rd; ex_is_load = s.ex_is_load; ex_result = s.ex_result;
        mem_we = s.mem_we; mem_rd = s.mem_rd; mem_result = s.mem_result;
        wb_we = s.wb_we; wb_rd = s.wb_rd; wb_wd = s.wb_wd; ex_flush = s.flush;
        sf = exp_stall(s, 1'b1);
        sn = exp_stall(s, 1'b0);
        stall_q.push_back({sn, sf});
        if (s.rst_n) begin
            pend_f = next_idex(pend_f, s, 1'b1, sf);
            pend_n = next_idex(pend_n, s, 1'b0, sn);
            if (s.wb_we && s.wb_rd != 0) rf_m[s.wb_rd] = s.wb_wd;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1'b1, if_valid: 1'b0, inst: 0, pc: 0, pc4: 0, sext: 0, rf_we: 0, wsel: 0,
              use1: 0, use2: 0, ex_we: 0, ex_rd: 0, ex_is_load: 0, ex_result: 0,
              mem_we: 0, mem_rd: 0, mem_result: 0, wb_we: 0, wb_rd: 0, wb_wd: 0, flush: 0};
        return s;
    endfunction

    function automatic stim_t decode(input logic [31:0] inst, input logic [2:0] sext);
        stim_t s;
        s = idle();
        s.if_valid = 1'b1; s.inst = inst; s.sext = sext; s.rf_we = 1'b1;
        s.use1 = 1'b1; s.use2 = 1'b1; s.pc = 32'h100; s.pc4 = 32'h104; s.wsel = 2'd1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = idle();
        s.rst_n      = ($urandom_range(0, 99) != 0);
        s.if_valid   = ($urandom_range(0, 9) != 0);
        s.inst       = $urandom;
        s.inst[19:15] = 5'($urandom_range(0, 7));
        s.inst[24:20] = 5'($urandom_range(0, 7));
        s.inst[11:7]  = 5'($urandom_range(0, 7));
        s.pc         = $urandom;
        s.pc4        = s.pc + 32'd4;
        s.sext       = 3'($urandom_range(0, 7));
        s.rf_we      = 1'($urandom);
        s.wsel       = 2'($urandom);
        s.use1       = ($urandom_range(0, 3) != 0);
        s.use2       = ($urandom_range(0, 3) != 0);
        s.ex_we      = 1'($urandom);
        s.ex_rd      = 5'($urandom_range(0, 7));
        s.ex_is_load = ($urandom_range(0, 3) == 0);
        s.ex_result  = $urandom;
        s.mem_we     = 1'($urandom);
        s.mem_rd     = 5'($urandom_range(0, 7));
        s.mem_result = $urandom;
        s.wb_we      = ($urandom_range(0, 9) < 7);
        s.wb_rd      = 5'($urandom_range(0, 7));
        s.wb_wd      = $urandom;
        s.flush      = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares whatever the scoreboard holds at each falling edge
    // ------------------------------------------------------------------
    task automatic cmp_idex(input string tag, input idex_t e, input idex_t a);
        chk({tag, ".valid"}, 32'(a.valid), 32'(e.valid));
        chk({tag, ".we"},    32'(a.we),    32'(e.we));
        if (e.valid || e.rst) begin
            chk({tag, ".pc"},   a.pc,   e.pc);
            chk({tag, ".pc4"},  a.pc4,  e.pc4);
            chk({tag, ".rd1"},  a.rd1,  e.rd1);
            chk({tag, ".rd2"},  a.rd2,  e.rd2);
            chk({tag, ".ext"},  a.ext,  e.ext);
            chk({tag, ".rd"},   32'(a.rd),   32'(e.rd));
            chk({tag, ".wsel"}, 32'(a.wsel), 32'(e.wsel));
        end
    endtask

    initial begin : monitor
        logic [1:0] st;
        idex_t      e, a;
        forever begin
            @(negedge clk);
            if (stall_q.size() > 0) begin
                st = stall_q.pop_front();
                chk("fwd.id_stall",   32'(f_stall), 32'(st[0]));
                chk("nofwd.id_stall", 32'(n_stall), 32'(st[1]));
            end
            if (exp_f_q.size() > 0) begin
                e = exp_f_q.pop_front();
                a = '{rst: 1'b0, valid: f_valid, we: f_we, pc: f_pc, pc4: f_pc4, rd1: f_rd1,
                      rd2: f_rd2, ext: f_ext, rd: f_rd, wsel: f_wsel};
                cmp_idex("fwd", e, a);
            end
            if (exp_n_q.size() > 0) begin
                e = exp_n_q.pop_front();
                a = '{rst: 1'b0, valid: n_valid, we: n_we, pc: n_pc, pc4: n_pc4, rd1: n_rd1,
                      rd2: n_rd2, ext: n_ext, rd: n_rd, wsel: n_wsel};
                cmp_idex("nofwd", e, a);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        stim_t s;
        s = idle();
        rst_n = 1'b0; if_valid = 0; if_inst = 0; if_pc = 0; if_pc4 = 0; ctl_sext_op = 0;
        ctl_rf_we = 0; ctl_rf_wsel = 0; ctl_use_rs1 = 0; ctl_use_rs2 = 0;
        ex_we = 0; ex_rd = 0; ex_is_load = 0; ex_result = 0; mem_we = 0; mem_rd = 0;
        mem_result = 0; wb_we = 0; wb_rd = 0; wb_wd = 0; ex_flush = 0;
        pend_f = zero_idex();
        pend_n = zero_idex();
        for (int r = 0; r < 32; r++) rf_m[r] = 32'h0;

        // Reset, WB write x5, then add x6,x5,x0
        s = idle(); s.rst_n = 1'b0; step(s); step(s);
        s = idle(); s.wb_we = 1; s.wb_rd = 5; s.wb_wd = 32'h1234; step(s);
        step(decode(32'h0002_8333, 3'd0));
        step(idle());

        // EX/MEM/WB all target x3: add x4,x3,x3
        s = decode(32'h0031_8233, 3'd0);
        s.ex_we = 1; s.ex_rd = 3; s.ex_result = 32'hAAAA;
        s.mem_we = 1; s.mem_rd = 3; s.mem_result = 32'hBBBB;
        s.wb_we = 1; s.wb_rd = 3; s.wb_wd = 32'hCCCC;
        step(s);
        s.ex_we = 0; step(s);
        step(idle());

        // Load-use on rs2=x7: add x8,x1,x7, then load moves to MEM
        s = decode(32'h0070_8433, 3'd0);
        s.ex_we = 1; s.ex_rd = 7; s.ex_is_load = 1; step(s);
        s.ex_we = 0; s.ex_is_load = 0; s.mem_we = 1; s.mem_rd = 7; s.mem_result = 32'h55; step(s);

        // Flush together with a load-use condition
        s = decode(32'h0070_8433, 3'd0);
        s.ex_we = 1; s.ex_rd = 7; s.ex_is_load = 1; s.flush = 1; step(s);

        // Immediates and x0 write
        step(decode(32'hFFF0_0093, 3'd0));
        step(decode(32'h0000_006F, 3'd4));
        s = idle(); s.wb_we = 1; s.wb_rd = 0; s.wb_wd = 32'h99; step(s);
        step(decode(32'h0000_0033, 3'd0));

        // Reset during a load-use stall, then x5 reads back 0
        s = decode(32'h0070_8433, 3'd0);
        s.ex_we = 1; s.ex_rd = 7; s.ex_is_load = 1; step(s);
        s.rst_n = 1'b0; step(s);
        step(decode(32'h0002_8333, 3'd0));

        // Non-load EX match: stalls only the non-forwarding build
        s = decode(32'h0031_8233, 3'd0);
        s.ex_we = 1; s.ex_rd = 3; s.ex_result = 32'h7777; step(s);
        s.ex_we = 0; step(s);

        for (int i = 0; i < 3000; i++) step(rand_stim());

        step(idle());
        step(idle());
        @(negedge clk);
        @(negedge clk);
        chk("drain.stall_q", 32'(stall_q.size()), 32'd0);
        chk("drain.exp_q",   32'(exp_f_q.size() + exp_n_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
